// File: rtl/rx_seq_counter_if.sv
// Receive-side sequence-counter bus: serial bit stream in, detection/count status out.
// master: the transmitter-facing driver (enable, bits, strobe, done).
// slave : the counter itself (consumes stream, reports pulses, count, busy, overflow).
interface rx_seq_counter_if #(
  parameter int CNT_W = 10
);
  logic             rx_en_n;
  logic             serial_bit;
  logic             bit_valid;
  logic             tx_done;
  logic             seq_detected;
  logic [CNT_W-1:0] seq_count;
  logic             count_valid;
  logic             busy;
  logic             overflow;

  modport master (
    output rx_en_n, serial_bit, bit_valid, tx_done,
    input  seq_detected, seq_count, count_valid, busy, overflow
  );

  modport slave (
    input  rx_en_n, serial_bit, bit_valid, tx_done,
    output seq_detected, seq_count, count_valid, busy, overflow
  );
endinterface

// File: rtl/rx_seq_counter.sv
// Counts overlapping PATTERN matches in a sliding window over a strobed serial stream.
// Latency: bit strobe -> seq_detected 1 cycle; tx_done -> count_valid 1 cycle.
// No backpressure: at most one bit per cycle is accepted whenever bit_valid is high in RECV.
// Ports: clk, rst_n (async active-low), bus (slave modport: rx_en_n, serial_bit, bit_valid,
//        tx_done in; seq_detected, seq_count, count_valid, busy, overflow out).
module rx_seq_counter #(
  parameter int               PAT_W   = 8,
  parameter logic [PAT_W-1:0] PATTERN = 8'hA5,
  parameter int               CNT_W   = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  rx_seq_counter_if.slave     bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int               FILL_W   = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
  // Window is complete once PAT_W-1 bits are already held and one more arrives.
  localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(PAT_W - 1);

  logic [1:0]       state;
  logic             en_n_d;
  logic [PAT_W-1:0] shreg;
  logic [FILL_W-1:0] fill;
  logic             det_q;
  logic [CNT_W-1:0] cnt_q;
  logic             cv_q;
  logic             ovf_q;

  logic             start;
  logic [PAT_W-1:0] win;
  logic             hit;
  logic             cnt_full;

  assign start    = en_n_d & ~bus.rx_en_n;
  assign win      = {shreg[PAT_W-2:0], bus.serial_bit};
  assign hit      = (win == PATTERN) && (fill >= FILL_ARM);
  assign cnt_full = &cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      en_n_d <= 1'b1;
      shreg  <= '0;
      fill   <= '0;
      det_q  <= 1'b0;
      cnt_q  <= '0;
      cv_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      en_n_d <= bus.rx_en_n;
      det_q  <= 1'b0;
      cv_q   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RECV;
            shreg <= '0;
            fill  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
          end
        end

        S_RECV: begin
          if (start) begin
            // Fresh frame: the abandoned one never reports a final count.
            shreg <= '0;
            fill  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
          end else if (bus.rx_en_n) begin
            // Abort: partial count and overflow remain visible.
            state <= S_IDLE;
          end else begin
            if (bus.bit_valid) begin
              // Shift register is never cleared on a match, so overlaps count.
              shreg <= win;
              if (fill != FILL_MAX) fill <= fill + FILL_W'(1);
              if (hit) begin
                det_q <= 1'b1;
                if (cnt_full) ovf_q <= 1'b1;
                else          cnt_q <= cnt_q + CNT_W'(1);
              end
            end
            // A bit arriving with tx_done is folded into the final count above.
            if (bus.tx_done) begin
              state <= S_DONE;
              cv_q  <= 1'b1;
            end
          end
        end

        S_DONE: begin
          // count_valid is already high this cycle; a start here still clears for the next frame.
          if (start) begin
            state <= S_RECV;
            shreg <= '0;
            fill  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
          end else begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.seq_detected = det_q;
  assign bus.seq_count    = cnt_q;
  assign bus.count_valid  = cv_q;
  assign bus.busy         = (state == S_RECV);
  assign bus.overflow     = ovf_q;

endmodule

// File: tb/tb_rx_seq_counter.sv
module tb_rx_seq_counter;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Four instances cover the differently parameterised scenarios:
  // 0: A5/8/10, 1: 1010/4, 2: 0000/4, 3: 11/2 with a 2-bit counter.
  logic       en_n [4];
  logic       sbit [4];
  logic       bv   [4];
  logic       done [4];
  logic       det  [4];
  logic       cv   [4];
  logic       busy [4];
  logic       ovf  [4];
  logic [9:0] cnt  [4];

  int det_cnt [4];
  int cv_cnt  [4];
  int errors = 0;
  int checks = 0;

  rx_seq_counter_if #(.CNT_W(10)) if0 ();
  rx_seq_counter_if #(.CNT_W(10)) if1 ();
  rx_seq_counter_if #(.CNT_W(10)) if2 ();
  rx_seq_counter_if #(.CNT_W(2))  if3 ();

  assign if0.rx_en_n = en_n[0]; assign if0.serial_bit = sbit[0];
  assign if0.bit_valid = bv[0]; assign if0.tx_done = done[0];
  assign det[0] = if0.seq_detected; assign cv[0] = if0.count_valid;
  assign busy[0] = if0.busy; assign ovf[0] = if0.overflow; assign cnt[0] = if0.seq_count;

  assign if1.rx_en_n = en_n[1]; assign if1.serial_bit = sbit[1];
  assign if1.bit_valid = bv[1]; assign if1.tx_done = done[1];
  assign det[1] = if1.seq_detected; assign cv[1] = if1.count_valid;
  assign busy[1] = if1.busy; assign ovf[1] = if1.overflow; assign cnt[1] = if1.seq_count;

  assign if2.rx_en_n = en_n[2]; assign if2.serial_bit = sbit[2];
  assign if2.bit_valid = bv[2]; assign if2.tx_done = done[2];
  assign det[2] = if2.seq_detected; assign cv[2] = if2.count_valid;
  assign busy[2] = if2.busy; assign ovf[2] = if2.overflow; assign cnt[2] = if2.seq_count;

  assign if3.rx_en_n = en_n[3]; assign if3.serial_bit = sbit[3];
  assign if3.bit_valid = bv[3]; assign if3.tx_done = done[3];
  assign det[3] = if3.seq_detected; assign cv[3] = if3.count_valid;
  assign busy[3] = if3.busy; assign ovf[3] = if3.overflow; assign cnt[3] = {8'b0, if3.seq_count};

  rx_seq_counter #(.PAT_W(8), .PATTERN(8'hA5),   .CNT_W(10)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  rx_seq_counter #(.PAT_W(4), .PATTERN(4'b1010), .CNT_W(10)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  rx_seq_counter #(.PAT_W(4), .PATTERN(4'b0000), .CNT_W(10)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  rx_seq_counter #(.PAT_W(2), .PATTERN(2'b11),   .CNT_W(2))  u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  // Pulse counters, sampled mid-cycle.
  initial begin
    for (int i = 0; i < 4; i++) begin
      det_cnt[i] = 0;
      cv_cnt[i]  = 0;
    end
  end
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (det[i] === 1'b1) det_cnt[i] = det_cnt[i] + 1;
      if (cv[i]  === 1'b1) cv_cnt[i]  = cv_cnt[i] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Assumes the instance is not in RECV (raising enable there would abort).
  task automatic start_frame(input int d);
    en_n[d] = 1'b1;
    tick();
    en_n[d] = 1'b0;
    tick();
  endtask

  task automatic send_bit(input int d, input logic b, input logic with_done);
    sbit[d] = b;
    bv[d]   = 1'b1;
    done[d] = with_done;
    tick();
    bv[d]   = 1'b0;
    done[d] = 1'b0;
  endtask

  task automatic finish_frame(input int d);
    done[d] = 1'b1;
    tick();
    done[d] = 1'b0;
  endtask

  logic [7:0] a5;
  logic [5:0] s_ovl;
  logic [5:0] e_ovl;
  int base;

  initial begin
    for (int i = 0; i < 4; i++) begin
      en_n[i] = 1'b1; sbit[i] = 1'b0; bv[i] = 1'b0; done[i] = 1'b0;
    end
    a5    = 8'hA5;
    s_ovl = 6'b101010;
    e_ovl = 6'b000101;

    // Reset state
    #2 rst_n = 1'b0;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_det%0d", i),  32'(det[i]),  32'd0);
      check($sformatf("rst_cnt%0d", i),  32'(cnt[i]),  32'd0);
      check($sformatf("rst_cv%0d", i),   32'(cv[i]),   32'd0);
      check($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'd0);
      check($sformatf("rst_ovf%0d", i),  32'(ovf[i]),  32'd0);
    end
    rst_n = 1'b1;
    tick();

    // Bits offered while idle are ignored
    base = det_cnt[0];
    for (int k = 7; k >= 0; k--) send_bit(0, a5[k], 1'b0);
    tick();
    check("idle_det", 32'(det_cnt[0] - base), 32'd0);
    check("idle_busy", 32'(busy[0]), 32'd0);

    // Single match, MSB first
    start_frame(0);
    check("t1_busy", 32'(busy[0]), 32'd1);
    for (int k = 7; k >= 0; k--) begin
      send_bit(0, a5[k], 1'b0);
      check($sformatf("t1_det_b%0d", 7 - k), 32'(det[0]), (k == 0) ? 32'd1 : 32'd0);
    end
    check("t1_cnt", 32'(cnt[0]), 32'd1);
    finish_frame(0);
    check("t1_cv", 32'(cv[0]), 32'd1);
    check("t1_cv_cnt", 32'(cnt[0]), 32'd1);
    check("t1_busy_done", 32'(busy[0]), 32'd0);
    tick();
    check("t1_cv_drop", 32'(cv[0]), 32'd0);
    check("t1_cnt_hold", 32'(cnt[0]), 32'd1);

    // Overlapping matches of 1010
    start_frame(1);
    for (int k = 5; k >= 0; k--) begin
      send_bit(1, s_ovl[k], 1'b0);
      check($sformatf("t2_det_b%0d", 6 - k), 32'(det[1]), 32'(e_ovl[k]));
    end
    finish_frame(1);
    check("t2_cv", 32'(cv[1]), 32'd1);
    check("t2_cnt", 32'(cnt[1]), 32'd2);
    tick();

    // Partial window of zeros must not match
    start_frame(2);
    for (int k = 0; k < 4; k++) begin
      send_bit(2, 1'b0, 1'b0);
      check($sformatf("t3_det_b%0d", k + 1), 32'(det[2]), (k == 3) ? 32'd1 : 32'd0);
    end
    finish_frame(2);
    check("t3_cnt", 32'(cnt[2]), 32'd1);
    tick();
    // Second frame: the fill count must restart even though the shift register already holds zeros
    start_frame(2);
    check("t3b_cnt_clr", 32'(cnt[2]), 32'd0);
    for (int k = 0; k < 3; k++) begin
      send_bit(2, 1'b0, 1'b0);
      check($sformatf("t3b_det_b%0d", k + 1), 32'(det[2]), 32'd0);
    end
    finish_frame(2);
    check("t3b_cnt", 32'(cnt[2]), 32'd0);
    tick();

    // Last bit and tx_done together
    start_frame(0);
    check("t4_cnt_clr", 32'(cnt[0]), 32'd0);
    for (int k = 7; k >= 1; k--) send_bit(0, a5[k], 1'b0);
    send_bit(0, a5[0], 1'b1);
    check("t4_det", 32'(det[0]), 32'd1);
    check("t4_cv", 32'(cv[0]), 32'd1);
    check("t4_cnt", 32'(cnt[0]), 32'd1);
    check("t4_busy", 32'(busy[0]), 32'd0);
    tick();
    check("t4_cv_drop", 32'(cv[0]), 32'd0);

    // Saturation with a 2-bit counter
    start_frame(3);
    base = det_cnt[3];
    for (int k = 0; k < 8; k++) send_bit(3, 1'b1, 1'b0);
    check("t5_cnt", 32'(cnt[3]), 32'd3);
    check("t5_ovf", 32'(ovf[3]), 32'd1);
    finish_frame(3);
    check("t5_cv", 32'(cv[3]), 32'd1);
    check("t5_cv_cnt", 32'(cnt[3]), 32'd3);
    check("t5_pulses", 32'(det_cnt[3] - base), 32'd7);
    tick();
    check("t5_ovf_hold", 32'(ovf[3]), 32'd1);
    start_frame(3);
    check("t5_ovf_clr", 32'(ovf[3]), 32'd0);
    check("t5_cnt_clr", 32'(cnt[3]), 32'd0);
    en_n[3] = 1'b1;
    tick();

    // Abort mid-frame keeps the partial count and never reports it
    start_frame(0);
    base = cv_cnt[0];
    for (int k = 7; k >= 0; k--) send_bit(0, a5[k], 1'b0);
    send_bit(0, 1'b1, 1'b0);
    en_n[0] = 1'b1;
    tick();
    check("t6_busy", 32'(busy[0]), 32'd0);
    check("t6_cnt", 32'(cnt[0]), 32'd1);
    finish_frame(0);            // tx_done outside RECV is ignored
    tick(); tick();
    check("t6_no_cv", 32'(cv_cnt[0] - base), 32'd0);
    check("t6_cnt_hold", 32'(cnt[0]), 32'd1);

    // Asynchronous reset mid-frame
    start_frame(0);
    for (int k = 7; k >= 0; k--) send_bit(0, a5[k], 1'b0);
    check("t7_pre_det", 32'(det[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t7_det", 32'(det[0]), 32'd0);
    check("t7_cnt", 32'(cnt[0]), 32'd0);
    check("t7_busy", 32'(busy[0]), 32'd0);
    check("t7_cv", 32'(cv[0]), 32'd0);
    check("t7_ovf", 32'(ovf[0]), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
